// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter for a shared system bus with up to 8 masters.
// A master is granted in IDLE. The grant is held until the bus transaction ends.
// Watchdogs withdraw an unused grant, and they end a stalled transaction with a
// one-cycle error pulse.
//
// Ports:
//   clock               system clock (rising edge)
//   reset               synchronous, active-high reset
//   busRequests         per-master request level, bit i = master i
//   beginTransactionIn  shared-bus beginTransaction
//   endTransactionIn    shared-bus endTransaction
//   busGrants           registered one-hot grant, zero when nobody is granted
//   busErrorOut         registered one-cycle pulse on transaction timeout
//   grantedId           index of the current or last granted master
//   busActive           high while in GRANT or BUSY
//
// state    | meaning
// IDLE     | no grant; arbitrate among pending requests
// GRANT    | grant held; waiting for the winner to begin a transaction
// BUSY     | transaction in progress; waiting for endTransaction
// RELEASE  | grant dropped for one cycle before returning to IDLE
module bus_arbiter #(
    parameter int nrOfMasters              = 4,
    parameter int grantTimeoutCycles       = 16,
    parameter int transactionTimeoutCycles = 1024
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [nrOfMasters-1:0] busRequests,
    input  logic                   beginTransactionIn,
    input  logic                   endTransactionIn,
    output logic [nrOfMasters-1:0] busGrants,
    output logic                   busErrorOut,
    output logic [2:0]             grantedId,
    output logic                   busActive
);

    localparam int MAX_TO = (grantTimeoutCycles > transactionTimeoutCycles) ?
                            grantTimeoutCycles : transactionTimeoutCycles;
    localparam int CNT_W  = (MAX_TO > 1) ? $clog2(MAX_TO) : 1;

    localparam logic [CNT_W-1:0] GRANT_TC = CNT_W'(grantTimeoutCycles - 1);
    localparam logic [CNT_W-1:0] TXN_TC   = CNT_W'(transactionTimeoutCycles - 1);
    localparam logic [2:0]       LAST_ID  = 3'(nrOfMasters - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_BUSY,
        ST_RELEASE
    } state_t;

    state_t                 state_q;
    logic [nrOfMasters-1:0] busGrants_q;
    logic                   busError_q;
    logic [2:0]             grantedId_q;
    logic                   busActive_q;
    logic [CNT_W-1:0]       grantCnt_q;
    logic [CNT_W-1:0]       txnCnt_q;

    logic [2:0]             winner_d;
    logic [nrOfMasters-1:0] onehot_d;
    logic                   found_d;
    int                     rank;
    int                     bestRank;

    // Circular search starting after grantedId. A master's rank is its distance
    // past the last grant. The requester with the smallest rank wins.
    always_comb begin
        winner_d = '0;
        onehot_d = '0;
        found_d  = 1'b0;
        rank     = 0;
        bestRank = nrOfMasters;
        for (int i = 0; i < nrOfMasters; i++) begin
            rank = (i + 2 * nrOfMasters - int'(grantedId_q) - 1) % nrOfMasters;
            if (busRequests[i] && (rank < bestRank)) begin
                bestRank = rank;
                winner_d = 3'(i);
                found_d  = 1'b1;
            end
        end
        for (int i = 0; i < nrOfMasters; i++) begin
            onehot_d[i] = found_d && (winner_d == 3'(i));
        end
    end

    // True only while the granted master still requests. It relies on busGrants_q
    // being one-hot, so no index into busRequests is needed.
    logic winnerReq;
    assign winnerReq = |(busRequests & busGrants_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            busGrants_q <= '0;
            busError_q  <= 1'b0;
            grantedId_q <= LAST_ID;
            busActive_q <= 1'b0;
            grantCnt_q  <= '0;
            txnCnt_q    <= '0;
        end else begin
            busError_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (found_d) begin
                        state_q     <= ST_GRANT;
                        busGrants_q <= onehot_d;
                        grantedId_q <= winner_d;
                        busActive_q <= 1'b1;
                        grantCnt_q  <= '0;
                    end
                end
                ST_GRANT: begin
                    grantCnt_q <= grantCnt_q + CNT_W'(1);
                    if (beginTransactionIn) begin
                        state_q  <= ST_BUSY;
                        txnCnt_q <= '0;
                    end else if (!winnerReq || (grantCnt_q == GRANT_TC)) begin
                        state_q     <= ST_RELEASE;
                        busGrants_q <= '0;
                        busActive_q <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    txnCnt_q <= txnCnt_q + CNT_W'(1);
                    if (endTransactionIn) begin
                        state_q     <= ST_RELEASE;
                        busGrants_q <= '0;
                        busActive_q <= 1'b0;
                    end else if (txnCnt_q == TXN_TC) begin
                        state_q     <= ST_RELEASE;
                        busGrants_q <= '0;
                        busActive_q <= 1'b0;
                        busError_q  <= 1'b1;
                    end
                end
                ST_RELEASE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    busGrants_q <= '0;
                    busActive_q <= 1'b0;
                end
            endcase
        end
    end

    assign busGrants   = busGrants_q;
    assign busErrorOut = busError_q;
    assign grantedId   = grantedId_q;
    assign busActive   = busActive_q;

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;
    localparam int N   = 4;
    localparam int GTO = 16;
    localparam int TTO = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic         beg;
    logic         en;
    logic [N-1:0] gnt;
    logic         err;
    logic [2:0]   gid;
    logic         act;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bus_arbiter #(
        .nrOfMasters(N),
        .grantTimeoutCycles(GTO),
        .transactionTimeoutCycles(TTO)
    ) dut (
        .clock(clk),
        .reset(rst),
        .busRequests(req),
        .beginTransactionIn(beg),
        .endTransactionIn(en),
        .busGrants(gnt),
        .busErrorOut(err),
        .grantedId(gid),
        .busActive(act)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp_v);
        tests++;
        if (got !== exp_v) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp_v, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: who owns the bus, how long they have held it, and whether
    // a transaction has started. The model is not written as a state machine.
    int m_owner;
    int m_last;
    int m_age;
    bit m_txn;
    bit m_gap;
    bit m_err;
    bit m_started = 1'b0;

    always @(posedge clk) begin
        int  w;
        bit  found;
        m_started = 1'b1;
        if (rst) begin
            m_owner = -1;
            m_last  = N - 1;
            m_age   = 0;
            m_txn   = 1'b0;
            m_gap   = 1'b0;
            m_err   = 1'b0;
        end else begin
            m_err = 1'b0;
            if (m_gap) begin
                m_gap = 1'b0;
            end else if (m_owner < 0) begin
                found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    w = (m_last + k) % N;
                    if (!found && req[w]) begin
                        found   = 1'b1;
                        m_owner = w;
                        m_last  = w;
                        m_age   = 0;
                        m_txn   = 1'b0;
                    end
                end
            end else if (!m_txn) begin
                if (beg) begin
                    m_txn = 1'b1;
                    m_age = 0;
                end else if (!req[m_owner] || m_age == GTO - 1) begin
                    m_owner = -1;
                    m_gap   = 1'b1;
                end else begin
                    m_age++;
                end
            end else begin
                if (en) begin
                    m_owner = -1;
                    m_gap   = 1'b1;
                end else if (m_age == TTO - 1) begin
                    m_owner = -1;
                    m_gap   = 1'b1;
                    m_err   = 1'b1;
                end else begin
                    m_age++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            check("cyc_grants", 32'(gnt), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
            check("cyc_error", 32'(err), 32'(m_err));
            check("cyc_id", 32'(gid), 32'(m_last));
            check("cyc_active", 32'(act), 32'(m_owner >= 0));
        end
    end

    task automatic wait_grant(output int n);
        n = 0;
        while (gnt == '0 && n < 40) begin
            step();
            n++;
        end
        check("wait_grant", 32'(gnt != '0), 32'd1);
    endtask

    initial begin
        int n;
        int cnt;
        bit errseen;
        int exp_order[6];
        exp_order = '{0, 1, 3, 0, 1, 3};

        rst = 1'b1; req = '0; beg = 1'b0; en = 1'b0;
        step(); step();
        check("rst_grants", 32'(gnt), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_id", 32'(gid), 32'd3);
        check("rst_active", 32'(act), 32'd0);
        rst = 1'b0;
        step(); step();

        // begin/end seen in IDLE are ignored
        beg = 1'b1; step(); beg = 1'b0;
        en = 1'b1; step(); en = 1'b0;
        check("idle_pulse_grants", 32'(gnt), 32'd0);
        check("idle_pulse_active", 32'(act), 32'd0);

        // single requester
        req = 4'b0100; step();
        check("single_grant", 32'(gnt), 32'b0100);
        check("single_id", 32'(gid), 32'd2);
        check("single_active", 32'(act), 32'd1);
        step();
        beg = 1'b1; step(); beg = 1'b0; req = '0;
        repeat (10) step();
        check("single_busy", 32'(gnt), 32'b0100);
        en = 1'b1; step(); en = 1'b0;
        check("single_end_grant", 32'(gnt), 32'd0);
        check("single_end_active", 32'(act), 32'd0);
        step();

        // round robin among masters 0, 1, 3
        rst = 1'b1; step(); rst = 1'b0;
        req = 4'b1011;
        for (int i = 0; i < 6; i++) begin
            wait_grant(n);
            check("rr_gap", 32'(n), 32'd1);
            check("rr_id", 32'(gid), 32'(exp_order[i]));
            check("rr_onehot", 32'(gnt), 32'd1 << exp_order[i]);
            beg = 1'b1; step(); beg = 1'b0;
            step(); step();
            en = 1'b1; step(); en = 1'b0;
            check("rr_end_drop", 32'(gnt), 32'd0);
            step();
            check("rr_idle", 32'(gnt), 32'd0);
        end
        req = '0;
        step();

        // grant timeout, then the next requester in order
        rst = 1'b1; step(); rst = 1'b0;
        req = 4'b0110; step();
        check("gto_grant", 32'(gnt), 32'b0010);
        cnt = 1; errseen = 1'b0;
        while (gnt != '0 && cnt < 40) begin
            step();
            errseen |= err;
            if (gnt != '0) cnt++;
        end
        check("gto_len", 32'(cnt), 32'd16);
        check("gto_noerr", 32'(errseen), 32'd0);
        step(); step();
        check("gto_next_grant", 32'(gnt), 32'b0100);
        check("gto_next_id", 32'(gid), 32'd2);

        // transaction timeout
        beg = 1'b1; req = '0; step(); beg = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (!err && n < 60);
        check("tto_len", 32'(n), 32'd32);
        check("tto_err", 32'(err), 32'd1);
        check("tto_grant", 32'(gnt), 32'd0);
        check("tto_active", 32'(act), 32'd0);
        en = 1'b1; step(); en = 1'b0;
        check("tto_pulse_width", 32'(err), 32'd0);
        check("tto_late_end", 32'(gnt), 32'd0);
        step();
        check("tto_idle_active", 32'(act), 32'd0);

        // request dropped before begin
        req = 4'b0001; step();
        check("drop_grant", 32'(gnt), 32'b0001);
        req = '0; step();
        check("drop_release", 32'(gnt), 32'd0);
        check("drop_noerr", 32'(err), 32'd0);
        step();

        // endTransaction on the terminal count cycle
        req = 4'b0001; step();
        check("tc_grant", 32'(gnt), 32'b0001);
        beg = 1'b1; req = '0; step(); beg = 1'b0;
        repeat (31) step();
        check("tc_still_busy", 32'(gnt), 32'b0001);
        en = 1'b1; step(); en = 1'b0;
        check("tc_noerr", 32'(err), 32'd0);
        check("tc_release", 32'(gnt), 32'd0);
        step();
        check("tc_noerr_late", 32'(err), 32'd0);

        // reset in the middle of BUSY
        req = 4'b0010; step();
        check("rb_grant", 32'(gnt), 32'b0010);
        beg = 1'b1; req = '0; step(); beg = 1'b0;
        repeat (5) step();
        check("rb_busy_active", 32'(act), 32'd1);
        rst = 1'b1; step(); rst = 1'b0;
        check("rb_grants", 32'(gnt), 32'd0);
        check("rb_err", 32'(err), 32'd0);
        check("rb_id", 32'(gid), 32'd3);
        check("rb_active", 32'(act), 32'd0);
        req = 4'b1111; step();
        check("rb_all_grant", 32'(gnt), 32'b0001);
        check("rb_all_id", 32'(gid), 32'd0);
        req = '0;
        beg = 1'b1; step(); beg = 1'b0;
        en = 1'b1; step(); en = 1'b0;
        step(); step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Round-robin arbiter for the shared system bus between up to 8 bus masters: camera grabber, CPU data port, DMA and similar.
- Takes each master's requestBus level and drives a one-hot busGrant vector.
- Holds a grant from beginTransaction until endTransaction on the shared bus.
- Watchdogs catch masters that stall; a stalled transaction is terminated with a single-cycle busError.

Parameters:
nrOfMasters, 4, number of requesters; legal range 1..8.
grantTimeoutCycles, 16, cycles a granted master may take to raise beginTransaction before the grant is withdrawn.
transactionTimeoutCycles, 1024, maximum cycles from beginTransaction to endTransaction before busError is issued.

Ports:
clock  input  1  system clock; all logic is on its rising edge.
reset  input  1  synchronous, active-high reset.
busRequests  input  nrOfMasters  per-master request level (requestBus); bit i belongs to master i.
beginTransactionIn  input  1  shared-bus beginTransaction (OR of all masters).
endTransactionIn  input  1  shared-bus endTransaction (OR of all masters).
busGrants  output  nrOfMasters  registered one-hot grant vector; all zero when no master is granted.
busErrorOut  output  1  registered single-cycle pulse on transaction timeout.
grantedId  output  3  index of the current or last granted master.
busActive  output  1  high in the GRANT and BUSY states.

Behaviour:
- Reset values: busGrants=0, busErrorOut=0, grantedId=nrOfMasters-1, busActive=0, state=IDLE, both counters=0.
- Priority pointer resets to nrOfMasters-1, so master 0 has highest priority after reset.
- Reset is taken in any state, including mid-transaction; outputs return to reset values on the next edge.
- States:
  - IDLE: no grant. If any busRequests bit is set, pick the first set bit searching circularly from grantedId+1 (mod nrOfMasters). Next edge: busGrants=onehot(winner), grantedId=winner, state=GRANT. If no bit is set, stay in IDLE.
  - GRANT: grant held and waiting for the master to begin.
    - beginTransactionIn=1 -> BUSY; transaction counter cleared.
    - Else the winner's request bit is 0 -> RELEASE.
    - Else the grant counter reaches grantTimeoutCycles-1 -> RELEASE. No error is raised.
    - Begin has priority over request drop and over the timeout in the same cycle.
  - BUSY: grant held while the granted master's request is ignored (the master drops requestBus after seeing the grant).
    - endTransactionIn=1 -> RELEASE.
    - Else the transaction counter reaches transactionTimeoutCycles-1 -> RELEASE with busErrorOut=1 for exactly one cycle. The master is expected to answer with endTransaction; that end is ignored.
    - endTransactionIn and timeout in the same cycle: end wins, no error.
  - RELEASE: busGrants=0 for one cycle, then IDLE unconditionally. beginTransactionIn and endTransactionIn are ignored.
- Latency:
  - Request seen in IDLE at cycle t -> grant visible at t+1.
  - endTransaction at cycle t -> grant low at t+1 -> IDLE at t+2 -> earliest next grant at t+3.
- Counters:
  - Width = clog2 of the larger timeout parameter.
  - Each counter increments only in its own state and clears on entry to that state. No wrap is possible because the state is left at terminal count.
- grantedId updates only when a new grant is issued. The round-robin pointer is grantedId, so a master that is withdrawn on timeout still loses priority.
- Bus begin/end pulses arriving while in IDLE are ignored (illegal traffic). No state change.
- nrOfMasters=1: degenerates to a single-grant controller. The same timing and timeouts apply.

Test Plan:
- Single requester: reset, master 2 requests at cycle 5 -> busGrants=0100 at cycle 6; begin at 8, end at 20 -> grant low at 21, busActive low at 21.
- Round-robin: masters 0, 1 and 3 request continuously, each doing a 4-cycle transaction -> grant order is 0, 1, 3, 0, 1, 3. Gap from each end to the next grant is 3 cycles; grantedId sequence matches.
- Grant timeout: master 1 requests but never begins -> grant withdrawn after 16 cycles in GRANT, busErrorOut stays 0. If master 1 and master 2 still request, master 2 is granted next.
- Transaction timeout: begin with no end (use transactionTimeoutCycles=32 in the bench) -> busErrorOut high for exactly 1 cycle, 32 cycles after BUSY entry. Grant drops the same edge; a late endTransaction from the master causes no effect.
- Request drop and collisions: master drops request in GRANT before begin -> RELEASE next cycle, no error. endTransaction coincident with terminal count -> no error pulse.
- Reset mid-BUSY: assert reset for 1 cycle -> busGrants=0, busErrorOut=0, grantedId=nrOfMasters-1 on the next edge. Subsequent simultaneous requests from all masters -> master 0 granted first.
